m_if_2_router: RTL and testbench



---
 rtl/m_if_2_router.sv | 176 +++++++++++++++++
 tb/tb_m_if_2_router.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/m_if_2_router.sv
// Mesh network interface: packs local 32-bit words into 73-bit flits under credit flow control
// and returns credits for received flits. Define IF_RX_ASSEMBLY_EN to build two-flit receive assembly.
module m_if_2_router #(
  parameter int         CREDIT_DEPTH  = 4,
  parameter int         MAX_PKT_FLITS = 2,
  parameter logic [1:0] VC            = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_comm_send_req,
  output logic        o_comm_send_ack,
  input  logic        i_data_valid,
  input  logic [31:0] i_data,
  input  logic [7:0]  i_src,
  input  logic [7:0]  i_dst,
  input  logic [7:0]  local_id,
  input  logic [5:0]  i_id,
  input  logic [5:0]  i_seq_len,
  input  logic [2:0]  i_credit,
  output logic [72:0] o_data,
  output logic        o_data_valid,
  input  logic [72:0] i_flit,
  output logic        o_credit_valid,
  output logic [2:0]  o_credit,
  output logic [63:0] o_data_input,
  output logic        o_data_input_valid,
  output logic        o_req_rx,
  input  logic        i_ack_rx
);

  localparam int CW = $clog2(CREDIT_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} tx_state_e;

  tx_state_e      state_q, state_d;
  logic [7:0]     src_q, dst_q;
  logic [5:0]     id_q, len_q, cnt_q;
  logic [31:0]    hold_q;
  logic           hold_vld_q;
  logic [CW-1:0]  credit_q;
  logic           ack_d, latch, capture, emit, emit_tail;
  logic [5:0]     limit;
  logic           at_limit, credit_in;

  // A nonzero length shorter than the hardware maximum wins; otherwise the maximum caps the packet.
  assign limit     = (len_q != 6'd0 && len_q < 6'(MAX_PKT_FLITS)) ? len_q : 6'(MAX_PKT_FLITS);
  assign at_limit  = (cnt_q >= limit);
  assign credit_in = i_credit[2] && (i_credit[1:0] == VC);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    latch     = 1'b0;
    capture   = 1'b0;
    emit      = 1'b0;
    emit_tail = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_comm_send_req && credit_q >= CW'(MAX_PKT_FLITS)) begin
          state_d = GRANT;
          ack_d   = 1'b1;
          latch   = 1'b1;
        end
      end
      GRANT: begin
        ack_d = 1'b1;
        if (hold_vld_q && (at_limit || !i_data_valid)) begin
          emit      = 1'b1;
          emit_tail = 1'b1;
          state_d   = DRAIN;
        end else if (i_data_valid && !at_limit) begin
          capture = 1'b1;
          emit    = hold_vld_q;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      o_comm_send_ack <= 1'b0;
      src_q           <= '0;
      dst_q           <= '0;
      id_q            <= '0;
      len_q           <= '0;
      cnt_q           <= '0;
      hold_q          <= '0;
      hold_vld_q      <= 1'b0;
      o_data          <= '0;
      o_data_valid    <= 1'b0;
    end else begin
      state_q         <= state_d;
      o_comm_send_ack <= ack_d;
      if (latch) begin
        src_q      <= i_src;
        dst_q      <= i_dst;
        id_q       <= i_id;
        len_q      <= i_seq_len;
        cnt_q      <= '0;
        hold_vld_q <= 1'b0;
      end
      if (capture) begin
        hold_q     <= i_data;
        hold_vld_q <= 1'b1;
        cnt_q      <= cnt_q + 6'd1;
      end
      if (emit_tail) hold_vld_q <= 1'b0;
      o_data_valid <= emit;
      o_data       <= emit ? {1'b1, emit_tail, dst_q, VC, src_q, id_q, 15'd0, hold_q} : '0;
    end
  end

  // Simultaneous return and emission cancel; the count is clamped to [0, CREDIT_DEPTH].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= CW'(CREDIT_DEPTH);
    end else if (credit_in && !emit) begin
      if (credit_q != CW'(CREDIT_DEPTH)) credit_q <= credit_q + 1'b1;
    end else if (emit && !credit_in) begin
      if (credit_q != '0) credit_q <= credit_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_credit_valid <= 1'b0;
      o_credit       <= '0;
    end else begin
      o_credit_valid <= i_flit[72];
      o_credit       <= i_flit[72] ? {1'b1, i_flit[62:61]} : 3'd0;
    end
  end

`ifdef IF_RX_ASSEMBLY_EN
  logic [31:0] rx_head_q;
  logic        rx_head_vld_q;
  logic        rx_unused;
  assign rx_unused = ^{local_id, i_flit[70:63], i_flit[60:32]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_head_q          <= '0;
      rx_head_vld_q      <= 1'b0;
      o_data_input       <= '0;
      o_data_input_valid <= 1'b0;
      o_req_rx           <= 1'b0;
    end else begin
      o_data_input_valid <= 1'b0;
      if (i_ack_rx) o_req_rx <= 1'b0;
      if (i_flit[72]) begin
        if (i_flit[71]) begin
          o_data_input       <= {rx_head_vld_q ? rx_head_q : 32'd0, i_flit[31:0]};
          o_data_input_valid <= 1'b1;
          o_req_rx           <= 1'b1;
          rx_head_vld_q      <= 1'b0;
        end else begin
          rx_head_q     <= i_flit[31:0];
          rx_head_vld_q <= 1'b1;
        end
      end
    end
  end
`else
  logic rx_unused;
  assign rx_unused          = ^{local_id, i_flit[71:63], i_flit[60:0], i_ack_rx};
  assign o_data_input       = '0;
  assign o_data_input_valid = 1'b0;
  assign o_req_rx           = 1'b0;
`endif

endmodule

// File: tb/tb_m_if_2_router.sv
// Directed self-checking bench for m_if_2_router: transmit packing, credit flow control,
// credit return and (when IF_RX_ASSEMBLY_EN is defined) receive assembly.
module tb_m_if_2_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_comm_send_req;
  logic        o_comm_send_ack;
  logic        i_data_valid;
  logic [31:0] i_data;
  logic [7:0]  i_src, i_dst, local_id;
  logic [5:0]  i_id, i_seq_len;
  logic [2:0]  i_credit;
  logic [72:0] o_data;
  logic        o_data_valid;
  logic [72:0] i_flit;
  logic        o_credit_valid;
  logic [2:0]  o_credit;
  logic [63:0] o_data_input;
  logic        o_data_input_valid;
  logic        o_req_rx;
  logic        i_ack_rx;

  int n_checks = 0;
  int n_fail   = 0;

  m_if_2_router #(.CREDIT_DEPTH(4), .MAX_PKT_FLITS(2), .VC(2'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_comm_send_req(i_comm_send_req), .o_comm_send_ack(o_comm_send_ack),
    .i_data_valid(i_data_valid), .i_data(i_data),
    .i_src(i_src), .i_dst(i_dst), .local_id(local_id),
    .i_id(i_id), .i_seq_len(i_seq_len), .i_credit(i_credit),
    .o_data(o_data), .o_data_valid(o_data_valid),
    .i_flit(i_flit), .o_credit_valid(o_credit_valid), .o_credit(o_credit),
    .o_data_input(o_data_input), .o_data_input_valid(o_data_input_valid),
    .o_req_rx(o_req_rx), .i_ack_rx(i_ack_rx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [72:0] flit(input logic tail, input logic [7:0] dst, input logic [1:0] vc,
                                       input logic [7:0] src, input logic [5:0] id, input logic [31:0] d);
    return {1'b1, tail, dst, vc, src, id, 15'd0, d};
  endfunction

  initial begin
    rst_n = 1'b0; i_comm_send_req = 0; i_data_valid = 0; i_data = '0;
    i_src = 8'd3; i_dst = 8'd8; local_id = 8'd1; i_id = 6'd5; i_seq_len = 6'd2;
    i_credit = '0; i_flit = '0; i_ack_rx = 0;
    #12 rst_n = 1'b1;
    tick();
    check("rst_ack", o_comm_send_ack, 0);
    check("rst_dvalid", o_data_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_cvalid", o_credit_valid, 0);
    check("rst_rxvalid", o_data_input_valid, 0);
    check("rst_req_rx", o_req_rx, 0);
    check("rst_credits", dut.credit_q, 4);

    // Two-word packet
    i_comm_send_req = 1; tick();
    check("two_ack_rise", o_comm_send_ack, 1);
    i_comm_send_req = 0; tick();
    i_data_valid = 1; i_data = 32'h40200000; tick();
    check("two_no_flit_yet", o_data_valid, 0);
    i_data = 32'h00000000; tick();
    check("two_head", o_data, flit(1'b0, 8'd8, 2'd0, 8'd3, 6'd5, 32'h40200000));
    check("two_head_hdr", o_data[72:71], 2'b10);
    i_data_valid = 0; tick();
    check("two_tail", o_data, flit(1'b1, 8'd8, 2'd0, 8'd3, 6'd5, 32'h0));
    check("two_ack_at_tail", o_comm_send_ack, 1);
    tick();
    check("two_ack_fall", o_comm_send_ack, 0);
    check("two_no_extra", o_data_valid, 0);
    check("two_credits", dut.credit_q, 2);

    // Single word, length 0
    i_seq_len = 0; i_id = 6'd7; i_comm_send_req = 1; tick();
    check("one_ack", o_comm_send_ack, 1);
    i_comm_send_req = 0; i_data_valid = 1; i_data = 32'hDEADBEEF; tick();
    i_data_valid = 0; tick();
    check("one_tail", o_data, flit(1'b1, 8'd8, 2'd0, 8'd3, 6'd7, 32'hDEADBEEF));
    tick(); tick();
    check("one_credits", dut.credit_q, 1);

    // Credit starvation; wrong-VC credit ignored
    i_seq_len = 6'd1; i_comm_send_req = 1; tick(); tick(); tick();
    check("starve_ack", o_comm_send_ack, 0);
    i_credit = 3'b101; tick(); i_credit = 3'b000; tick();
    check("starve_wrong_vc", o_comm_send_ack, 0);
    i_credit = 3'b100; tick(); i_credit = 3'b000;
    check("starve_still_low", o_comm_send_ack, 0);
    tick();
    check("starve_grant", o_comm_send_ack, 1);

    // Length limit 1 with two valid words
    i_comm_send_req = 0; i_data_valid = 1; i_data = 32'hAAAA0001; tick();
    i_data = 32'hAAAA0002; tick();
    check("limit_tail", o_data, flit(1'b1, 8'd8, 2'd0, 8'd3, 6'd7, 32'hAAAA0001));
    i_data_valid = 0; tick();
    check("limit_no_second", o_data_valid, 0);
    tick();
    check("limit_credits", dut.credit_q, 1);
    i_credit = 3'b100; tick(); i_credit = 3'b000;
    check("return_credits", dut.credit_q, 2);

    // Simultaneous credit return and emission
    i_seq_len = 0; i_comm_send_req = 1; tick();
    i_comm_send_req = 0; i_data_valid = 1; i_data = 32'h12345678; tick();
    i_data_valid = 0; i_credit = 3'b100; tick(); i_credit = 3'b000;
    check("simul_flit", o_data, flit(1'b1, 8'd8, 2'd0, 8'd3, 6'd7, 32'h12345678));
    check("simul_credits", dut.credit_q, 2);
    tick(); tick();

    // Saturation at CREDIT_DEPTH
    i_credit = 3'b100; tick(); tick(); tick(); i_credit = 3'b000;
    check("sat_credits", dut.credit_q, 4);

    // Receive: non-tail then tail on VC 2
    i_flit = flit(1'b0, 8'd1, 2'd2, 8'd8, 6'd0, 32'h3FF00000); tick();
    i_flit = flit(1'b1, 8'd1, 2'd2, 8'd8, 6'd0, 32'h00000001);
    check("rx_cvalid1", o_credit_valid, 1);
    check("rx_credit1", o_credit, 3'b110);
    tick();
    i_flit = '0;
    check("rx_cvalid2", o_credit_valid, 1);
`ifdef IF_RX_ASSEMBLY_EN
    check("rx_valid", o_data_input_valid, 1);
    check("rx_data", o_data_input, 64'h3FF0000000000001);
    check("rx_req", o_req_rx, 1);
`else
    check("rx_valid_tied", o_data_input_valid, 0);
    check("rx_data_tied", o_data_input, 0);
    check("rx_req_tied", o_req_rx, 0);
`endif
    tick();
    check("rx_cvalid_off", o_credit_valid, 0);
    check("rx_valid_pulse", o_data_input_valid, 0);
    tick();
`ifdef IF_RX_ASSEMBLY_EN
    check("rx_req_held", o_req_rx, 1);
`else
    check("rx_req_held_tied", o_req_rx, 0);
`endif
    i_ack_rx = 1; tick(); i_ack_rx = 0;
    check("rx_req_clear", o_req_rx, 0);
    i_flit = flit(1'b1, 8'd1, 2'd1, 8'd9, 6'd0, 32'hCAFE0000); tick(); i_flit = '0;
    check("rx_single_credit", o_credit, 3'b101);
`ifdef IF_RX_ASSEMBLY_EN
    check("rx_single_data", o_data_input, 64'h00000000CAFE0000);
`else
    check("rx_single_tied", o_data_input, 0);
`endif

    // Reset mid-packet abandons it
    i_comm_send_req = 1; tick();
    i_comm_send_req = 0; i_data_valid = 1; i_data = 32'h55555555; tick();
    i_data_valid = 0; rst_n = 1'b0; #2;
    check("midrst_ack", o_comm_send_ack, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("midrst_no_flit", o_data_valid, 0);
    end
    check("midrst_credits", dut.credit_q, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
